channel_phase_generator: RTL and testbench

// - Produces the 8-bit `period` phase word that the channel's waveform generators consume
//   (triangle, saw, square); `period` is 0x00..0xFF across one waveform cycle.
// - Sequential phase accumulator with a registered tuning word and a note gate.
// - Uses a drain state so a released note finishes its cycle at phase 0, avoiding clicks.

---
 rtl/channel_phase_generator_pkg.sv | 17 +
 rtl/channel_phase_generator_if.sv | 17 +
 rtl/channel_phase_generator_phase_accumulator.sv | 36 +++
 rtl/channel_phase_generator.sv | 134 +++++++++++++
 tb/tb_channel_phase_generator.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/channel_phase_generator_pkg.sv
// Shared types for the channel phase generator.
//   PHASE_W        width of the phase word handed to the waveform generators
//   phase_t        phase word type (0x00..0xFF across one waveform cycle)
//   phase_state_e  note-gate FSM states
package synth_pkg;

  localparam int PHASE_W = 8;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_RUN,
    PH_DRAIN
  } phase_state_e;

endpackage

// File: rtl/channel_phase_generator_if.sv
// Tuning-word valid/ready handshake.
//   freq_word   phase increment per sample tick
//   freq_valid  freq_word valid
//   freq_ready  receiver has a free pending slot
// The master drives the word; the slave (the phase generator) drives ready.
interface channel_phase_generator_if #(
  parameter int INC_W = 16
) ();

  logic [INC_W-1:0] freq_word;
  logic             freq_valid;
  logic             freq_ready;

  modport master (output freq_word, output freq_valid, input freq_ready);
  modport slave  (input freq_word, input freq_valid, output freq_ready);

endinterface

// File: rtl/channel_phase_generator_phase_accumulator.sv
// Phase accumulator: acc + zero-extended inc, modulo 2^ACC_W.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear of acc (wins over en)
//   en          take one accumulation step this cycle
//   inc         phase increment, INC_W bits
//   acc         accumulator register
//   carry       carry-out of acc + inc for the current register contents
module phase_accumulator #(
  parameter int ACC_W = 24,
  parameter int INC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic [ACC_W-1:0] acc,
  output logic             carry
);

  logic [ACC_W:0] sum;

  assign sum   = {1'b0, acc} + {{(ACC_W + 1 - INC_W){1'b0}}, inc};
  assign carry = sum[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/channel_phase_generator.sv
// Channel phase generator: phase accumulator with a registered tuning word,
// a note gate, and a drain state that lets a released note finish its cycle
// at phase 0.
//   clk, rst_n   clock, asynchronous active-low reset
//   sample_tick  one-cycle strobe at the audio sample rate
//   gate         note on (level)
//   sync_in      hard sync; forces phase to 0
//   freq_if      tuning-word handshake (slave side)
//   period       phase word, top 8 bits of the accumulator
//   wrap         registered one-cycle pulse when the accumulator carries out
//   active       FSM is not idle
module channel_phase_generator
  import synth_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int INC_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_tick,
  input  logic                      gate,
  input  logic                      sync_in,
  channel_phase_generator_if.slave  freq_if,
  output phase_t                    period,
  output logic                      wrap,
  output logic                      active
);

  phase_state_e     state, state_next;
  logic [INC_W-1:0] inc;
  logic [INC_W-1:0] pending;
  logic             pend_vld;
  logic [ACC_W-1:0] acc;
  logic             carry;
  logic             acc_clr, acc_en, wrap_next;

  assign freq_if.freq_ready = ~pend_vld;
  assign period             = acc[ACC_W-1 -: PHASE_W];
  assign active             = (state != PH_IDLE);

  // The pending slot is only refilled while empty, so load and drain can
  // never collide; inc moves on a tick regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc      <= '0;
      pending  <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (sample_tick && pend_vld) begin
        inc      <= pending;
        pend_vld <= 1'b0;
      end
      if (freq_if.freq_valid && !pend_vld) begin
        pending  <= freq_if.freq_word;
        pend_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    wrap_next  = 1'b0;
    case (state)
      PH_IDLE: begin
        acc_clr = 1'b1;
        if (gate) state_next = PH_RUN;
      end
      PH_RUN: begin
        if (sync_in) begin
          acc_clr = 1'b1;
        end else if (sample_tick) begin
          acc_en    = 1'b1;
          wrap_next = carry;
        end
        if (!gate) state_next = PH_DRAIN;
      end
      PH_DRAIN: begin
        if (sync_in) begin
          acc_clr    = 1'b1;
          state_next = PH_IDLE;
        end else if (gate) begin
          // Re-triggered note resumes from the current phase.
          state_next = PH_RUN;
          if (sample_tick) begin
            acc_en    = 1'b1;
            wrap_next = carry;
          end
        end else if (sample_tick) begin
          if (carry) begin
            acc_clr    = 1'b1;
            wrap_next  = 1'b1;
            state_next = PH_IDLE;
          end else if (inc == '0) begin
            // A zero increment would never carry; stop instead of hanging.
            acc_clr    = 1'b1;
            state_next = PH_IDLE;
          end else begin
            acc_en = 1'b1;
          end
        end
      end
      default: begin
        acc_clr    = 1'b1;
        state_next = PH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PH_IDLE;
      wrap  <= 1'b0;
    end else begin
      state <= state_next;
      wrap  <= wrap_next;
    end
  end

  phase_accumulator #(
    .ACC_W (ACC_W),
    .INC_W (INC_W)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .inc   (inc),
    .acc   (acc),
    .carry (carry)
  );

endmodule

// File: tb/tb_channel_phase_generator.sv
module tb_channel_phase_generator;
  import synth_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   sample_tick, gate, sync_in;
  phase_t period;
  logic   wrap, active;

  channel_phase_generator_if #(.INC_W(16)) fi ();

  channel_phase_generator #(
    .ACC_W (24),
    .INC_W (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .gate        (gate),
    .sync_in     (sync_in),
    .freq_if     (fi),
    .period      (period),
    .wrap        (wrap),
    .active      (active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] period;
    logic       wrap;
    logic       active;
    logic       ready;
  } exp_t;

  typedef struct packed {
    logic        tick;
    logic        gate;
    logic        sync;
    logic        valid;
    logic [15:0] word;
    exp_t        exp;
  } vec_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check_out();
    exp_t  e;
    string n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    vectors++;
    if (period !== e.period || wrap !== e.wrap || active !== e.active ||
        fi.freq_ready !== e.ready) begin
      miscompares++;
      $display("FAIL %s: got period=%02h wrap=%b active=%b ready=%b, expected period=%02h wrap=%b active=%b ready=%b",
               n, period, wrap, active, fi.freq_ready, e.period, e.wrap, e.active, e.ready);
    end
  endtask

  task automatic check_now(input string name, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(name);
    check_out();
  endtask

  task automatic apply(input string name, input vec_t v);
    sample_tick   = v.tick;
    gate          = v.gate;
    sync_in       = v.sync;
    fi.freq_valid = v.valid;
    fi.freq_word  = v.word;
    exp_q.push_back(v.exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    check_out();
  endtask

  function automatic vec_t mk(input logic tick, input logic g, input logic sync,
                              input logic valid, input logic [15:0] word,
                              input logic [7:0] p, input logic w, input logic a,
                              input logic r);
    vec_t v;
    v.tick  = tick;
    v.gate  = g;
    v.sync  = sync;
    v.valid = valid;
    v.word  = word;
    v.exp   = '{period: p, wrap: w, active: a, ready: r};
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hs_tbl[5];
    vec_t z_tbl[6];
    logic g;

    //             tick  gate  sync  valid word     per    wrap  act   rdy
    hs_tbl[0] = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h1000, 8'h00, 1'b0, 1'b0, 1'b0);
    hs_tbl[1] = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h2222, 8'h00, 1'b0, 1'b0, 1'b0);
    hs_tbl[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
    hs_tbl[3] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);
    hs_tbl[4] = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);

    z_tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    z_tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
    z_tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);
    z_tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);
    z_tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);
    z_tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);

    rst_n = 1'b0;
    sample_tick = 1'b0;
    gate = 1'b0;
    sync_in = 1'b0;
    fi.freq_valid = 1'b0;
    fi.freq_word = '0;
    #3;
    check_now("reset", '{period: 8'h00, wrap: 1'b0, active: 1'b0, ready: 1'b1});
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;

    // Handshake: first word taken, second stalled, one tick loads inc=0x1000.
    for (int i = 0; i < 5; i++) apply($sformatf("handshake[%0d]", i), hs_tbl[i]);

    // 0x1000 per tick: period = n/16, carry on tick 4096. Idle cycles in
    // between must hold the phase and keep wrap low.
    for (int n = 2; n <= 4096; n++) begin
      apply($sformatf("run_tick[%0d]", n),
            mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 8'((n >> 4) & 'hFF), n == 4096, 1'b1, 1'b1));
      apply($sformatf("run_hold[%0d]", n),
            mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 8'((n >> 4) & 'hFF), 1'b0, 1'b1, 1'b1));
    end

    // Word accepted on a tick: that tick and the loading tick still add 0x1000.
    apply("coinc_accept", mk(1'b1, 1'b1, 1'b0, 1'b1, 16'h8000, 8'h00, 1'b0, 1'b1, 1'b0));
    apply("coinc_load",   mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0,    8'h00, 1'b0, 1'b1, 1'b1));
    apply("coinc_new0",   mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0,    8'h00, 1'b0, 1'b1, 1'b1));
    apply("coinc_new1",   mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0,    8'h01, 1'b0, 1'b1, 1'b1));

    // Drain with inc=0x8000: period = k/2; gate dropped at 0x40, re-raised
    // at k=131 (RUN wraps with active held), dropped again to end at k=1024.
    apply("sync_run", mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b1));
    for (int k = 1; k <= 1024; k++) begin
      g = (k <= 128) || (k >= 131 && k <= 512);
      apply($sformatf("drain[%0d]", k),
            mk(1'b1, g, 1'b0, 1'b0, 16'h0, 8'((k >> 1) & 'hFF),
               (k == 512) || (k == 1024), k != 1024, 1'b1));
    end
    apply("drain_after", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b1));

    // inc=0 drain terminates on the next tick without a wrap pulse.
    for (int i = 0; i < 6; i++) apply($sformatf("zero_inc[%0d]", i), z_tbl[i]);

    // Reach acc=0xFFF000 with inc=0xF000, switch inc to 0x2000, then sync+tick.
    apply("s5_accept", mk(1'b0, 1'b0, 1'b0, 1'b1, 16'hF000, 8'h00, 1'b0, 1'b0, 1'b0));
    apply("s5_load",   mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0,    8'h00, 1'b0, 1'b0, 1'b1));
    apply("s5_gate",   mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0,    8'h00, 1'b0, 1'b1, 1'b1));
    for (int k = 1; k <= 273; k++) begin
      apply($sformatf("s5_tick[%0d]", k),
            mk(1'b1, 1'b1, 1'b0, k == 272, 16'h2000, 8'(((k * 'hF000) >> 16) & 'hFF),
               1'b0, 1'b1, k != 272));
    end
    apply("sync_tick", mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b1));
    for (int j = 1; j <= 8; j++) begin
      apply($sformatf("post_sync[%0d]", j),
            mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 8'(((j * 'h2000) >> 16) & 'hFF), 1'b0, 1'b1, 1'b1));
    end

    // Asynchronous reset mid-RUN with a word pending.
    apply("pre_reset", mk(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 8'h01, 1'b0, 1'b1, 1'b0));
    fi.freq_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_now("async_reset", '{period: 8'h00, wrap: 1'b0, active: 1'b0, ready: 1'b1});
    #1 rst_n = 1'b1;
    apply("post_rst0", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b1));
    apply("post_rst1", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b1));
    apply("post_rst2", mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b1));
    apply("post_rst3", mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b1));

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
